dec_round_ctrl: RTL

DEC_ROUND_CTRL -- requirements
Module: dec_round_ctrl

---
 rtl/dec_round_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/dec_round_ctrl.sv
// Iterative inverse-cipher round controller: key buffer, IDLE/ROUND/DONE FSM, and
// muxing to an external one-round datapath. Optional macro DEC_KEY_LOCK_EN freezes keys while busy.
module dec_round_ctrl #(
   parameter int ROUNDS = 10
) (
   input  logic         i_Clk,
   input  logic         i_Rst_n,
   input  logic         i_Key_Wr,
   input  logic [3:0]   i_Key_Addr,
   input  logic [127:0] i_Key_Data,
   input  logic         i_Din_Valid,
   output logic         o_Din_Ready,
   input  logic [127:0] i_Din,
   output logic [3:0]   o_Round_Times,
   output logic [127:0] o_Round_Key,
   output logic [127:0] o_Round_Din,
   input  logic [127:0] i_Round_Dout,
   output logic         o_Dout_Valid,
   input  logic         i_Dout_Ready,
   output logic [127:0] o_Dout,
   output logic         o_Busy
);

   localparam logic [3:0] LAST_IDX  = 4'(ROUNDS);
   localparam logic [3:0] FIRST_CNT = 4'(ROUNDS - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;

   state_t         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [127:0]   blk_q, blk_d;
   logic [127:0]   key_q [ROUNDS+1];
   logic           key_we;

   // Out-of-range indices are dropped rather than aliased onto a real entry.
   always_comb begin
      key_we = i_Key_Wr && (i_Key_Addr <= LAST_IDX);
`ifdef DEC_KEY_LOCK_EN
      key_we = key_we && (state_q == IDLE);
`endif
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         for (int i = 0; i <= ROUNDS; i++) key_q[i] <= '0;
      end else if (key_we) begin
         key_q[i_Key_Addr] <= i_Key_Data;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      blk_d   = blk_q;
      case (state_q)
         IDLE: begin
            if (i_Din_Valid) begin
               blk_d   = i_Din ^ key_q[ROUNDS];
               cnt_d   = FIRST_CNT;
               state_d = ROUND;
            end
         end
         ROUND: begin
            blk_d = i_Round_Dout;
            if (cnt_q == 4'd0) state_d = DONE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         DONE: begin
            if (i_Dout_Ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         blk_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         blk_q   <= blk_d;
      end
   end

   // All outputs are decodes of registered state, so reset clears them without a clock.
   assign o_Din_Ready   = (state_q == IDLE);
   assign o_Busy        = (state_q != IDLE);
   assign o_Dout_Valid  = (state_q == DONE);
   assign o_Dout        = (state_q == DONE)  ? blk_q         : '0;
   assign o_Round_Din   = (state_q == ROUND) ? blk_q         : '0;
   assign o_Round_Times = (state_q == ROUND) ? cnt_q         : '0;
   assign o_Round_Key   = (state_q == ROUND) ? key_q[cnt_q]  : '0;

endmodule
